disp_mux_4dig: RTL and testbench

//   Time-multiplexing driver for a 4-digit common-anode seven-segment display.

---
 rtl/disp_mux_4dig.sv | 53 +++++
 tb/tb_disp_mux_4dig.sv | 82 ++++++++
 2 files changed

// File: rtl/disp_mux_4dig.sv
// disp_mux_4dig: scans four active-low segment words onto one bus, one anode at a time.
// Optional inter-digit blanking is enabled by defining DISP_MUX_BLANK_EN.
module disp_mux_4dig #(
    parameter int REFRESH_BITS = 18,
    parameter int BLANK_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic [7:0] in3,
    output logic [3:0] an,
    output logic [7:0] sseg,
    output logic       frame_tick
);
    if (REFRESH_BITS < 3) begin : g_bad_bits
        $error("REFRESH_BITS must be at least 3");
    end
    if (BLANK_CYCLES >= 2 ** (REFRESH_BITS - 2)) begin : g_bad_blank
        $error("BLANK_CYCLES must be shorter than a digit slot");
    end
    logic [REFRESH_BITS-1:0] r_q;
    logic                    r_wrap;
    logic [1:0]              w_sel;
    logic [7:0]              w_word;
    logic                    w_blank;
    assign w_sel  = r_q[REFRESH_BITS-1:REFRESH_BITS-2];
    assign w_word = w_sel == 2'd0 ? in0 : w_sel == 2'd1 ? in1 : w_sel == 2'd2 ? in2 : in3;
`ifdef DISP_MUX_BLANK_EN
    localparam logic [REFRESH_BITS-3:0] BLANK_LIM = (REFRESH_BITS - 2)'(BLANK_CYCLES);
    assign w_blank = r_q[REFRESH_BITS-3:0] < BLANK_LIM;
`else
    assign w_blank = 1'b0;
`endif
    // Refresh counter plus registered anode/segment/strobe outputs; the strobe is
    // delayed one cycle behind the all-ones count so it lines up with the first digit-0 cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q        <= '0;
            r_wrap     <= 1'b0;
            an         <= 4'b1111;
            sseg       <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            r_q        <= r_q + REFRESH_BITS'(1);
            r_wrap     <= &r_q;
            an         <= w_blank ? 4'b1111 : ~(4'b0001 << w_sel);
            sseg       <= w_blank ? 8'hFF : w_word;
            frame_tick <= r_wrap;
        end
    end
endmodule

// File: tb/tb_disp_mux_4dig.sv
// tb_disp_mux_4dig: directed checks of scan order, frame strobe, live update and mid-slot reset.
module tb_disp_mux_4dig;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in0 = 8'hC0;
    logic [7:0] in1 = 8'hF9;
    logic [7:0] in2 = 8'hA4;
    logic [7:0] in3 = 8'hB0;
    logic [3:0] an;
    logic [7:0] sseg;
    logic       frame_tick;
    int         checks = 0;
    int         failures = 0;

    disp_mux_4dig #(.REFRESH_BITS(4), .BLANK_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .an(an), .sseg(sseg), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] word(input int d);
        return d == 0 ? in0 : d == 1 ? in1 : d == 2 ? in2 : in3;
    endfunction

    // n = edges since reset release; outputs after edge n reflect count n-1
    task automatic scan_step(input int n, input string tag);
        int   d;
        logic blank;
        logic [3:0] ea;
        logic [7:0] es;
        d = ((n - 1) / 4) % 4;
`ifdef DISP_MUX_BLANK_EN
        blank = ((n - 1) % 4) == 0;
`else
        blank = 1'b0;
`endif
        ea = blank ? 4'b1111 : (d == 0 ? 4'b1110 : d == 1 ? 4'b1101 : d == 2 ? 4'b1011 : 4'b0111);
        es = blank ? 8'hFF : word(d);
        step();
        chk({tag, "_an"}, {4'h0, an}, {4'h0, ea});
        chk({tag, "_sseg"}, sseg, es);
        chk({tag, "_tick"}, {7'h0, frame_tick}, {7'h0, (n > 1) && ((n - 1) % 16 == 0)});
        chk({tag, "_onehot"}, {7'h0, $countones(~an) <= 1}, 8'h01);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_an", {4'h0, an}, 8'h0F);
            chk("rst_sseg", sseg, 8'hFF);
            chk("rst_tick", {7'h0, frame_tick}, 8'h00);
        end
        reset = 1'b0;
        for (int n = 1; n <= 38; n++) begin
            scan_step(n, "scan");
            if (n == 26) in2 = 8'h9C;
        end
        reset = 1'b1;
        step();
        chk("midrst_an", {4'h0, an}, 8'h0F);
        chk("midrst_sseg", sseg, 8'hFF);
        chk("midrst_tick", {7'h0, frame_tick}, 8'h00);
        reset = 1'b0;
        for (int n = 1; n <= 20; n++) scan_step(n, "restart");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
